multiword_adder_sequencer: RTL and testbench

Sequencer that performs WORDS×8-bit add/subtract by time-multiplexing one 8-bit dataflow ripple-carry adder, one byte slice per clock, least-significant slice first. The carry is registered between slices. It sits between a requester issuing wide operands with a start/done handshake and the shared 8-bit adder datapath, so wide arithmetic costs no extra adder area.

---
 rtl/multiword_adder_sequencer_pkg.sv | 18 +
 rtl/multiword_adder_sequencer_rca.sv | 23 ++
 rtl/multiword_adder_sequencer.sv | 98 +++++++++
 tb/tb_multiword_adder_sequencer.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/multiword_adder_sequencer_pkg.sv
// Shared definitions for the multiword adder sequencer: slice width, FSM encoding
// and the signed-overflow helper for the most-significant slice.
package multiword_adder_sequencer_pkg;

    localparam int SLICE_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // The carry into the MSB is recovered from its sum bit, so the adder needs no extra port.
    function automatic logic msb_overflow(input logic a_msb, input logic b_msb,
                                          input logic s_msb, input logic carry_out);
        return (a_msb ^ b_msb ^ s_msb) ^ carry_out;
    endfunction

endpackage

// File: rtl/multiword_adder_sequencer_rca.sv
// 8-bit dataflow ripple-carry adder shared by the sequencer, one slice per clock.
module multiword_adder_sequencer_rca
    import multiword_adder_sequencer_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] S,
    output logic               Cout
);

    logic [SLICE_W:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[SLICE_W];

endmodule

// File: rtl/multiword_adder_sequencer.sv
// Wide add/subtract built by stepping one shared 8-bit adder over the operands,
// least-significant slice first, with the carry held in a register between slices.
module multiword_adder_sequencer
    import multiword_adder_sequencer_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       sub,
    input  logic                       cin,
    input  logic [SLICE_W*WORDS-1:0]   a,
    input  logic [SLICE_W*WORDS-1:0]   b,
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*WORDS-1:0]   sum,
    output logic                       cout,
    output logic                       ovf
);

    localparam int W     = SLICE_W * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t             state;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               sub_reg;
    logic               carry_reg;
    logic [IDX_W-1:0]   idx;

    logic [SLICE_W-1:0] a_slice;
    logic [SLICE_W-1:0] b_slice;
    logic [SLICE_W-1:0] s_slice;
    logic               c_slice;

    always_comb begin
        a_slice = a_reg[SLICE_W*idx +: SLICE_W];
        b_slice = b_reg[SLICE_W*idx +: SLICE_W] ^ {SLICE_W{sub_reg}};
    end

    multiword_adder_sequencer_rca u_rca (
        .A    (a_slice),
        .B    (b_slice),
        .Cin  (carry_reg),
        .S    (s_slice),
        .Cout (c_slice)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        sub_reg   <= sub;
                        carry_reg <= sub | cin;
                        idx       <= '0;
                        sum       <= '0;
                        ovf       <= 1'b0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    sum[SLICE_W*idx +: SLICE_W] <= s_slice;
                    carry_reg <= c_slice;
                    idx       <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= c_slice;
                        ovf   <= msb_overflow(a_slice[SLICE_W-1], b_slice[SLICE_W-1],
                                              s_slice[SLICE_W-1], c_slice);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// Directed bench for the multiword adder sequencer with WORDS=4.
module tb_multiword_adder_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic         cin = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int total = 0;
    int bad   = 0;

    multiword_adder_sequencer #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .cin   (cin),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one operation, optionally re-pulsing start mid-run, and checks the result.
    task automatic run_op(input string tag, input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic op_sub, input logic op_cin, input logic poke,
                          input logic [W-1:0] exp_sum, input logic exp_cout, input logic exp_ovf);
        int n;
        int busy_cycles;
        a = op_a;
        b = op_b;
        sub = op_sub;
        cin = op_cin;
        start = 1'b1;
        step();
        start = 1'b0;
        a = ~op_a;
        b = ~op_b;
        n = 0;
        busy_cycles = 0;
        while (!done && n < 20) begin
            if (busy) busy_cycles++;
            if (poke && n == 1) begin
                start = 1'b1;
                a = 32'h1234_5678;
                b = 32'h0F0F_0F0F;
            end else begin
                start = 1'b0;
            end
            step();
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'd4);
        check({tag, "_busy_cycles"}, 64'(busy_cycles), 64'd4);
        check({tag, "_done"}, 64'(done), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(cout), 64'(exp_cout));
        check({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
    endtask

    initial begin
        int done_seen;

        step();
        step();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_sum",  64'(sum),  64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_ovf",  64'(ovf),  64'd0);

        run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        step();
        check("done_one_cycle", 64'(done), 64'd0);
        step();
        check("sum_held", 64'(sum), 64'h0000_0100);

        run_op("ripple_cin", 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        run_op("sub_5_7", 32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        run_op("sub_min_1", 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

        step();
        run_op("start_in_run", 32'h1020_3040, 32'h0101_0101, 1'b0, 1'b0, 1'b1, 32'h1121_3141, 1'b0, 1'b0);
        run_op("start_in_done", 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0);

        step();
        a = 32'hFFFF_FFFF;
        b = 32'h0000_0001;
        sub = 1'b0;
        cin = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_run_busy", 64'(busy), 64'd0);
        check("rst_run_done", 64'(done), 64'd0);
        check("rst_run_sum",  64'(sum),  64'd0);
        check("rst_run_cout", 64'(cout), 64'd0);
        check("rst_run_ovf",  64'(ovf),  64'd0);
        done_seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done || busy) done_seen++;
        end
        check("rst_run_no_done", 64'(done_seen), 64'd0);

        run_op("after_rst", 32'h0101_0101, 32'h0101_0101, 1'b0, 1'b0, 1'b0, 32'h0202_0202, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
